burst_toggle_gen: RTL

Parametrised multi-channel burst waveform generator. On a start request, each channel loads a programmable initial level and then toggles a programmable number of times, with a programmable half-period. Each channel can update on the rising edge or the falling edge of the single clock, giving half-cycle skew between channels. It sits in the waveform/protocol stimulus area and replaces fixed-count, fixed-phase toggle generators.

---
 rtl/burst_toggle_gen.sv | 92 +++++++++
 1 files changed

// File: rtl/burst_toggle_gen.sv
// burst_toggle_gen: multi-channel burst toggle generator with per-channel rising/falling edge output phase
module burst_toggle_gen #(
  parameter int NCH = 2,
  parameter int CNT_W = 8,
  parameter int HP_W = 4,
  parameter logic [NCH-1:0] RST_LVL = 2'b10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] num_toggles,
  input  logic [HP_W-1:0]  half_period,
  input  logic [NCH-1:0]   init_level,
  input  logic [NCH-1:0]   edge_sel,
  output logic [NCH-1:0]   sig,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [NCH-1:0]   lvl_q, lvl_d;
  logic [NCH-1:0]   fall_q, fall_d;
  logic [NCH-1:0]   es_q, es_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] tgl_q, tgl_d;
  logic [HP_W-1:0]  hpm1_q, hpm1_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic             due, last;
  assign due  = hp_q == hpm1_q;
  assign last = tgl_q + CNT_W'(1) == n_q;
  // next-state, config latch and counter/level update for the rising-edge core
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    es_d    = es_q;
    n_d     = n_q;
    tgl_d   = tgl_q;
    hpm1_d  = hpm1_q;
    hp_d    = hp_q;
    case (state_q)
      IDLE: if (start && !stop) begin
        n_d     = num_toggles;
        hpm1_d  = half_period == '0 ? '0 : half_period - HP_W'(1);
        es_d    = edge_sel;
        lvl_d   = init_level;
        hp_d    = '0;
        tgl_d   = '0;
        state_d = num_toggles == '0 ? DONE : RUN;
      end
      RUN: if (stop) state_d = IDLE;
      else if (due) begin
        hp_d    = '0;
        lvl_d   = ~lvl_q;
        tgl_d   = tgl_q + CNT_W'(1);
        state_d = last ? DONE : RUN;
      end else hp_d = hp_q + HP_W'(1);
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // the falling-edge copy only follows the core while a burst is active
  always_comb fall_d = state_q != IDLE ? lvl_q : fall_q;
  // rising-edge core registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lvl_q   <= RST_LVL;
      es_q    <= '0;
      n_q     <= '0;
      tgl_q   <= '0;
      hpm1_q  <= '0;
      hp_q    <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      es_q    <= es_d;
      n_q     <= n_d;
      tgl_q   <= tgl_d;
      hpm1_q  <= hpm1_d;
      hp_q    <= hp_d;
    end
  end
  // falling-edge shadow of the level, giving half-cycle skew
  always_ff @(negedge clk or posedge rst) begin
    if (rst) fall_q <= RST_LVL;
    else fall_q <= fall_d;
  end
  assign sig  = (es_q & fall_q) | (~es_q & lvl_q);
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
endmodule
